// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and arithmetic helper for the approximate-error sweeper.
package sweep_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
   localparam int DW = 16;
   function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return a > b ? a - b : b - a;
   endfunction
endpackage

// File: rtl/approx_err_sweeper_if.sv
// approx_err_sweeper_if: control, circuit-under-test and result signals of the sweeper.
interface approx_err_sweeper_if #(parameter int IN_W = 4, parameter int OUT_W = 3);
   logic start, abort, busy, done, valid, pass;
   logic [IN_W-1:0] vec, fail_vec;
   logic [OUT_W-1:0] exact_in, approx_in, max_err;
   logic [OUT_W+IN_W-1:0] sum_err;
   logic [IN_W:0] err_cnt;
   modport master (output start, abort, exact_in, approx_in,
                   input vec, busy, done, valid, pass, max_err, sum_err, err_cnt, fail_vec);
   modport slave (input start, abort, exact_in, approx_in,
                  output vec, busy, done, valid, pass, max_err, sum_err, err_cnt, fail_vec);
endinterface

// File: rtl/err_accum.sv
// err_accum: sample register plus error statistics (max, sum, nonzero count, first failing vector).
module err_accum import sweep_pkg::*; #(
   parameter int IN_W = 4,
   parameter int OUT_W = 3,
   parameter int ET = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic sample,
   input  logic [IN_W-1:0] vec,
   input  logic [OUT_W-1:0] exact,
   input  logic [OUT_W-1:0] approx,
   output logic hit,
   output logic pass,
   output logic [OUT_W-1:0] max_err,
   output logic [OUT_W+IN_W-1:0] sum_err,
   output logic [IN_W:0] err_cnt,
   output logic [IN_W-1:0] fail_vec
);
   logic s1_valid, failed, upd, over;
   logic [IN_W-1:0] s1_vec;
   logic [OUT_W-1:0] s1_exact, s1_approx, e;
   always_comb begin
      e = OUT_W'(abs_diff(DW'(s1_exact), DW'(s1_approx)));
      upd = s1_valid && en;
      over = int'(e) > ET;
      hit = upd && over && !failed;
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s1_valid <= 1'b0;
         s1_vec <= '0;
         s1_exact <= '0;
         s1_approx <= '0;
         failed <= 1'b0;
         max_err <= '0;
         sum_err <= '0;
         err_cnt <= '0;
         fail_vec <= '0;
         pass <= !rst;
      end else begin
         s1_valid <= sample;
         if (sample) begin
            s1_vec <= vec;
            s1_exact <= exact;
            s1_approx <= approx;
         end
         if (upd) begin
            if (e > max_err) max_err <= e;
            sum_err <= sum_err + (OUT_W+IN_W)'(e);
            err_cnt <= err_cnt + (IN_W+1)'(e != '0);
            if (over) begin
               pass <= 1'b0;
               failed <= 1'b1;
               if (!failed) fail_vec <= s1_vec;
            end
         end
      end
   end
endmodule

// File: rtl/approx_err_sweeper.sv
// approx_err_sweeper: walks every input vector through exact and approximate circuits and
// scores the absolute output error against threshold ET.
module approx_err_sweeper import sweep_pkg::*; #(
   parameter int IN_W = 4,
   parameter int OUT_W = 3,
   parameter int ET = 3,
   parameter int STOP_ON_FAIL = 0
) (
   input logic clk,
   input logic rst,
   approx_err_sweeper_if.slave bus
);
   state_t state, state_n;
   logic [IN_W-1:0] vec;
   logic valid, hit, clr, sample, stop;
   always_comb begin
      clr = state == IDLE && bus.start;
      stop = (STOP_ON_FAIL != 0) && hit;
      // an early stop drops the sample being taken this cycle
      sample = state == SWEEP && !bus.abort && !stop;
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start ? SWEEP : IDLE;
         SWEEP:   state_n = (bus.abort || stop) ? DONE : (vec == '1) ? DRAIN : SWEEP;
         DRAIN:   state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vec <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_n;
         if (clr) begin
            vec <= '0;
            valid <= 1'b0;
         end else if (state == SWEEP) vec <= vec + IN_W'(1);
         if (state != DONE && state_n == DONE) valid <= !bus.abort;
      end
   end
   assign bus.vec = vec;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.valid = valid;
   err_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) u_acc (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en(!bus.abort),
      .sample(sample),
      .vec(vec),
      .exact(bus.exact_in),
      .approx(bus.approx_in),
      .hit(hit),
      .pass(bus.pass),
      .max_err(bus.max_err),
      .sum_err(bus.sum_err),
      .err_cnt(bus.err_cnt),
      .fail_vec(bus.fail_vec)
   );
endmodule

// File: tb/tb_approx_err_sweeper.sv
// tb_approx_err_sweeper: directed table plus abort/reset sequences on a normal and a stop-on-fail sweeper.
module tb_approx_err_sweeper;
   localparam int O_BUSY = 0, O_DONE = 1, O_VALID = 2, O_PASS = 3, O_MAX = 4;
   localparam int O_SUM = 5, O_CNT = 6, O_FV = 7, O_VEC = 8;
   typedef struct {
      int mode; int d; int cyc; int valid; int pass; int max; int sum; int cnt; int fv;
   } row_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start [2];
   logic abort [2];
   int mode = 0;
   int tests = 0;
   int fails = 0;
   row_t rows [5];
   always #5 clk = ~clk;
   function automatic logic [2:0] exact_of(input logic [3:0] v);
      return v[1:0] > v[3:2] ? 3'(v[1:0] - v[3:2]) : 3'(v[3:2] - v[1:0]);
   endfunction
   function automatic logic [2:0] approx_of(input int m, input logic [3:0] v);
      logic [2:0] x;
      x = exact_of(v);
      if (m == 1 && v == 4'd5) return x + 3'd4;
      if (m == 2) return x ^ 3'b001;
      if (m == 3 && (v == 4'd2 || v == 4'd9)) return x + 3'd5;
      return x;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : g_d
      approx_err_sweeper_if #(.IN_W(4), .OUT_W(3)) bus ();
      int o [9];
      assign bus.start = start[g];
      assign bus.abort = abort[g];
      assign bus.exact_in = exact_of(bus.vec);
      assign bus.approx_in = approx_of(mode, bus.vec);
      always_comb o = '{int'(bus.busy), int'(bus.done), int'(bus.valid), int'(bus.pass),
                        int'(bus.max_err), int'(bus.sum_err), int'(bus.err_cnt),
                        int'(bus.fail_vec), int'(bus.vec)};
      approx_err_sweeper #(.IN_W(4), .OUT_W(3), .ET(3), .STOP_ON_FAIL(g)) dut (
         .clk(clk),
         .rst(rst),
         .bus(bus.slave)
      );
   end
   function automatic int ob(input int d, input int k);
      return d != 0 ? g_d[1].o[k] : g_d[0].o[k];
   endfunction
   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   task automatic run_row(input int i);
      row_t r;
      int n;
      r = rows[i];
      mode = r.mode;
      start[r.d] = 1'b1;
      @(negedge clk);
      start[r.d] = 1'b0;
      n = 1;
      chk($sformatf("r%0d busy1", i), ob(r.d, O_BUSY), 1);
      while (ob(r.d, O_DONE) == 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("r%0d done_cycle", i), n, r.cyc);
      chk($sformatf("r%0d valid", i), ob(r.d, O_VALID), r.valid);
      chk($sformatf("r%0d pass", i), ob(r.d, O_PASS), r.pass);
      chk($sformatf("r%0d max_err", i), ob(r.d, O_MAX), r.max);
      chk($sformatf("r%0d sum_err", i), ob(r.d, O_SUM), r.sum);
      chk($sformatf("r%0d err_cnt", i), ob(r.d, O_CNT), r.cnt);
      chk($sformatf("r%0d fail_vec", i), ob(r.d, O_FV), r.fv);
      @(negedge clk);
      chk($sformatf("r%0d busy_after", i), ob(r.d, O_BUSY) + ob(r.d, O_DONE), 0);
      chk($sformatf("r%0d valid_held", i), ob(r.d, O_VALID), r.valid);
   endtask
   initial begin
      int pulses;
      rows[0] = '{mode: 0, d: 0, cyc: 18, valid: 1, pass: 1, max: 0, sum: 0,  cnt: 0,  fv: 0};
      rows[1] = '{mode: 1, d: 0, cyc: 18, valid: 1, pass: 0, max: 4, sum: 4,  cnt: 1,  fv: 5};
      rows[2] = '{mode: 2, d: 0, cyc: 18, valid: 1, pass: 1, max: 1, sum: 16, cnt: 16, fv: 0};
      rows[3] = '{mode: 3, d: 1, cyc: 5,  valid: 1, pass: 0, max: 5, sum: 5,  cnt: 1,  fv: 2};
      rows[4] = '{mode: 3, d: 0, cyc: 18, valid: 1, pass: 0, max: 5, sum: 10, cnt: 2,  fv: 2};
      start = '{1'b0, 1'b0};
      abort = '{1'b0, 1'b0};
      repeat (2) @(negedge clk);
      chk("reset busy", ob(0, O_BUSY), 0);
      chk("reset pass", ob(0, O_PASS), 0);
      chk("reset valid", ob(1, O_VALID), 0);
      chk("reset vec", ob(0, O_VEC), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) run_row(i);
      // abort at cycle 7 with a stray start at cycle 4
      mode = 2;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort no_early_done", ob(0, O_DONE), 0);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort done", ob(0, O_DONE), 1);
      chk("abort valid", ob(0, O_VALID), 0);
      chk("abort sum_err", ob(0, O_SUM), 5);
      chk("abort err_cnt", ob(0, O_CNT), 5);
      chk("abort pass", ob(0, O_PASS), 1);
      @(negedge clk);
      chk("abort busy_after", ob(0, O_BUSY), 0);
      chk("abort done_after", ob(0, O_DONE), 0);
      // reset at cycle 10 of a sweep
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy", ob(0, O_BUSY), 0);
      chk("rst done", ob(0, O_DONE), 0);
      chk("rst pass", ob(0, O_PASS), 0);
      chk("rst sum_err", ob(0, O_SUM), 0);
      chk("rst err_cnt", ob(0, O_CNT), 0);
      chk("rst max_err", ob(0, O_MAX), 0);
      chk("rst vec", ob(0, O_VEC), 0);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         pulses += ob(0, O_DONE);
      end
      chk("rst no_done", pulses, 0);
      run_row(0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
